// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage that sits directly behind the execute-stage ALU.
// Non-memory ops are passed through as a registered writeback beat one cycle
// after capture. Loads and stores run a req/ack transaction on the data bus,
// and mem_blocked holds the ALU while that transaction is outstanding.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a bus watchdog
// abandons a transaction after TIMEOUT un-acked BUS cycles and pulses
// mem_fault. When it is undefined, BUS waits for ack indefinitely and
// mem_fault is tied to 0.

module mem_access_stage #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              exe_mem,
  input  logic [1:0]        mem_op,
  input  logic [63:0]       alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  dst_reg,
  input  logic              dst_wen,
  input  logic [63:0]       alu_rflags,
  output logic              mem_blocked,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_wen,
  output logic [63:0]       wb_data,
  output logic [63:0]       wb_rflags,
  output logic              mem_fault
);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t            r_state, w_nextState;
  logic              r_busReq, w_busReq;
  logic              r_busWe, w_busWe;
  logic [ADDR_W-1:0] r_busAddr, w_busAddr;
  logic [DATA_W-1:0] r_busWdata, w_busWdata;
  logic [REG_W-1:0]  r_dstReg, w_dstReg;
  logic              r_dstWen, w_dstWen;
  logic [63:0]       r_rflags, w_rflags;
  logic              r_wbValid, w_wbValid;
  logic [REG_W-1:0]  r_wbReg, w_wbReg;
  logic              r_wbWen, w_wbWen;
  logic [63:0]       r_wbData, w_wbData;
  logic [63:0]       r_wbRflags, w_wbRflags;
  logic              r_fault, w_fault;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count, w_count;
`endif

  // Next-state and next-output decode: capture in IDLE, complete or time out in BUS
  always_comb begin
    w_nextState = r_state;
    w_busReq    = r_busReq;
    w_busWe     = r_busWe;
    w_busAddr   = r_busAddr;
    w_busWdata  = r_busWdata;
    w_dstReg    = r_dstReg;
    w_dstWen    = r_dstWen;
    w_rflags    = r_rflags;
    w_wbValid   = 1'b0;
    w_wbReg     = r_wbReg;
    w_wbWen     = r_wbWen;
    w_wbData    = r_wbData;
    w_wbRflags  = r_wbRflags;
    w_fault     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    w_count     = r_count;
`endif

    case (r_state)
      IDLE: begin
        if (exe_mem) begin
          if (mem_op == 2'b01 || mem_op == 2'b10) begin
            w_nextState = BUS;
            w_busReq    = 1'b1;
            w_busWe     = mem_op[1];
            w_busAddr   = ADDR_W'(alu_result);
            if (mem_op[1]) begin
              w_busWdata = store_data;
            end
            w_dstReg    = dst_reg;
            w_dstWen    = dst_wen;
            w_rflags    = alu_rflags;
`ifdef MEM_TIMEOUT_EN
            w_count     = '0;
`endif
          end else begin
            // 00 is a plain pass-through; 11 (reserved) is the same but never writes a GPR
            w_wbValid  = 1'b1;
            w_wbReg    = dst_reg;
            w_wbWen    = dst_wen & ~mem_op[0];
            w_wbData   = alu_result;
            w_wbRflags = alu_rflags;
          end
        end
      end

      BUS: begin
        if (bus_ack) begin
          w_nextState = IDLE;
          w_busReq    = 1'b0;
          w_wbValid   = 1'b1;
          w_wbReg     = r_dstReg;
          w_wbRflags  = r_rflags;
          if (r_busWe) begin
            w_wbWen  = 1'b0;
            w_wbData = 64'(r_busAddr);
          end else begin
            w_wbWen  = r_dstWen;
            w_wbData = 64'(bus_rdata);
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_count == LAST_CNT) begin
          w_nextState = IDLE;
          w_busReq    = 1'b0;
          w_wbValid   = 1'b1;
          w_wbReg     = r_dstReg;
          w_wbWen     = 1'b0;
          w_wbData    = 64'(r_busAddr);
          w_wbRflags  = r_rflags;
          w_fault     = 1'b1;
        end else begin
          w_count = r_count + CNT_W'(1);
        end
`endif
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_dstReg   <= '0;
      r_dstWen   <= 1'b0;
      r_rflags   <= '0;
      r_wbValid  <= 1'b0;
      r_wbReg    <= '0;
      r_wbWen    <= 1'b0;
      r_wbData   <= '0;
      r_wbRflags <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_busReq   <= w_busReq;
      r_busWe    <= w_busWe;
      r_busAddr  <= w_busAddr;
      r_busWdata <= w_busWdata;
      r_dstReg   <= w_dstReg;
      r_dstWen   <= w_dstWen;
      r_rflags   <= w_rflags;
      r_wbValid  <= w_wbValid;
      r_wbReg    <= w_wbReg;
      r_wbWen    <= w_wbWen;
      r_wbData   <= w_wbData;
      r_wbRflags <= w_wbRflags;
      r_fault    <= w_fault;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog counter of un-acked BUS cycles, cleared when a transaction starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count;
    end
  end

  assign mem_fault = r_fault;
`else
  assign mem_fault = 1'b0;
`endif

  assign mem_blocked = (r_state == BUS);
  assign bus_req     = r_busReq;
  assign bus_we      = r_busWe;
  assign bus_addr    = r_busAddr;
  assign bus_wdata   = r_busWdata;
  assign wb_valid    = r_wbValid;
  assign wb_reg      = r_wbReg;
  assign wb_wen      = r_wbWen;
  assign wb_data     = r_wbData;
  assign wb_rflags   = r_wbRflags;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage.
// A queue of expected writeback beats is filled as ops are issued or acked,
// and a compare process drains it on every cycle that carries a beat.
// Build with MEM_TIMEOUT_EN defined to also exercise the bus watchdog.

module tb_mem_access_stage;

  logic        clk;
  logic        reset_n;
  logic        exe_mem;
  logic [1:0]  mem_op;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [3:0]  dst_reg;
  logic        dst_wen;
  logic [63:0] alu_rflags;
  logic        mem_blocked;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        wb_wen;
  logic [63:0] wb_data;
  logic [63:0] wb_rflags;
  logic        mem_fault;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  reg_;
    logic        wen;
    logic [63:0] data;
    logic [63:0] flags;
    logic        chkData;
    logic        fault;
  } beat_t;

  beat_t expQ[$];

  mem_access_stage #(
    .ADDR_W (64),
    .DATA_W (64),
    .REG_W  (4),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .exe_mem    (exe_mem),
    .mem_op     (mem_op),
    .alu_result (alu_result),
    .store_data (store_data),
    .dst_reg    (dst_reg),
    .dst_wen    (dst_wen),
    .alu_rflags (alu_rflags),
    .mem_blocked(mem_blocked),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_wen     (wb_wen),
    .wb_data    (wb_data),
    .wb_rflags  (wb_rflags),
    .mem_fault  (mem_fault)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it and report when it does not hold
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive the execute-stage side of the interface
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [63:0] res,
                               input logic [63:0] sdata, input logic [3:0] dreg,
                               input logic wen, input logic [63:0] flags);
    exe_mem    = v;
    mem_op     = op;
    alu_result = res;
    store_data = sdata;
    dst_reg    = dreg;
    dst_wen    = wen;
    alu_rflags = flags;
  endtask

  task automatic expectBeat(input logic [3:0] r, input logic wen, input logic [63:0] data,
                            input logic [63:0] flags, input logic chk, input logic fault);
    beat_t b;
    b.reg_    = r;
    b.wen     = wen;
    b.data    = data;
    b.flags   = flags;
    b.chkData = chk;
    b.fault   = fault;
    expQ.push_back(b);
  endtask

  // Every cycle out of reset: blocked tracks the outstanding request, and each beat matches the model in order
  always @(negedge clk) begin
    if (reset_n) begin
      checkOutput("blockedEqReq", {63'd0, mem_blocked}, {63'd0, bus_req});
      if (wb_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("beatReg", {60'd0, wb_reg}, {60'd0, e.reg_});
          checkOutput("beatWen", {63'd0, wb_wen}, {63'd0, e.wen});
          checkOutput("beatFlags", wb_rflags, e.flags);
          checkOutput("beatFault", {63'd0, mem_fault}, {63'd0, e.fault});
          if (e.chkData) begin
            checkOutput("beatData", wb_data, e.data);
          end
        end
      end else begin
        checkOutput("idleFault", {63'd0, mem_fault}, 64'd0);
      end
    end
  end

  // Directed sequence
  initial begin
    reset_n   = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    #1;
    checkOutput("rstBusReq", {63'd0, bus_req}, 64'd0);
    checkOutput("rstBlocked", {63'd0, mem_blocked}, 64'd0);
    checkOutput("rstWbValid", {63'd0, wb_valid}, 64'd0);
    checkOutput("rstWbData", wb_data, 64'd0);
    checkOutput("rstFault", {63'd0, mem_fault}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Pass-through, one-cycle latency
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 64'h1234, 64'd0, 4'd3, 1'b1, 64'h0246);
    expectBeat(4'd3, 1'b1, 64'h1234, 64'h0246, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("ptValid", {63'd0, wb_valid}, 64'd1);
    checkOutput("ptData", wb_data, 64'h1234);
    checkOutput("ptReg", {60'd0, wb_reg}, 64'd3);
    checkOutput("ptWen", {63'd0, wb_wen}, 64'd1);
    checkOutput("ptBlocked", {63'd0, mem_blocked}, 64'd0);
    checkOutput("ptBusReq", {63'd0, bus_req}, 64'd0);

    // Back-to-back pass-through, second one reserved so its write enable is dropped
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 64'h1111, 64'd0, 4'd1, 1'b1, 64'h0001);
    expectBeat(4'd1, 1'b1, 64'h1111, 64'h0001, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 64'h2222, 64'd0, 4'd2, 1'b1, 64'h0002);
    expectBeat(4'd2, 1'b0, 64'h2222, 64'h0002, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("rsvValid", {63'd0, wb_valid}, 64'd1);
    checkOutput("rsvWen", {63'd0, wb_wen}, 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    @(posedge clk); #1;
    checkOutput("gapValid", {63'd0, wb_valid}, 64'd0);
    checkOutput("gapDataHeld", wb_data, 64'h2222);

    // Ack with no request outstanding is ignored
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 64'hBAD;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("strayAckReq", {63'd0, bus_req}, 64'd0);
      checkOutput("strayAckValid", {63'd0, wb_valid}, 64'd0);
    end
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;

    // Load acked on the third BUS cycle
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 64'h1000, 64'd0, 4'd5, 1'b1, 64'h0044);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
      checkOutput("ldBusReq", {63'd0, bus_req}, 64'd1);
      checkOutput("ldBlocked", {63'd0, mem_blocked}, 64'd1);
      checkOutput("ldAddr", bus_addr, 64'h1000);
      checkOutput("ldWe", {63'd0, bus_we}, 64'd0);
      checkOutput("ldNoBeat", {63'd0, wb_valid}, 64'd0);
    end
    bus_ack   = 1'b1;
    bus_rdata = 64'hDEADBEEF;
    expectBeat(4'd5, 1'b1, 64'hDEADBEEF, 64'h0044, 1'b1, 1'b0);
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    checkOutput("ldDoneReq", {63'd0, bus_req}, 64'd0);
    checkOutput("ldDoneValid", {63'd0, wb_valid}, 64'd1);
    checkOutput("ldDoneData", wb_data, 64'hDEADBEEF);
    @(negedge clk);
    checkOutput("ldPulseEnds", {63'd0, wb_valid}, 64'd0);

    // Store acked on the first BUS cycle
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 64'h2000, 64'h55, 4'd9, 1'b1, 64'h0080);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    checkOutput("stWe", {63'd0, bus_we}, 64'd1);
    checkOutput("stWdata", bus_wdata, 64'h55);
    checkOutput("stAddr", bus_addr, 64'h2000);
    bus_ack = 1'b1;
    expectBeat(4'd9, 1'b0, 64'h2000, 64'h0080, 1'b1, 1'b0);
    @(negedge clk);
    bus_ack = 1'b0;
    checkOutput("stValid", {63'd0, wb_valid}, 64'd1);
    checkOutput("stWen", {63'd0, wb_wen}, 64'd0);

    // Load followed by a pass-through the ALU holds while blocked
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 64'h3000, 64'd0, 4'd7, 1'b1, 64'h0011);
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 64'h77, 64'd0, 4'd8, 1'b1, 64'h0022);
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 64'hCAFEF00D;
    expectBeat(4'd7, 1'b1, 64'hCAFEF00D, 64'h0011, 1'b1, 1'b0);
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    checkOutput("ordBlocked", {63'd0, mem_blocked}, 64'd0);
    checkOutput("ordFirst", wb_data, 64'hCAFEF00D);
    expectBeat(4'd8, 1'b1, 64'h77, 64'h0022, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    checkOutput("ordSecond", wb_data, 64'h77);
    @(negedge clk);
    checkOutput("ordNoDup", {63'd0, wb_valid}, 64'd0);

    // Reset in the middle of a load abandons it without a beat
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 64'h4000, 64'd0, 4'd4, 1'b1, 64'h0033);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    checkOutput("rstMidReqBefore", {63'd0, bus_req}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstMidReq", {63'd0, bus_req}, 64'd0);
    checkOutput("rstMidBlocked", {63'd0, mem_blocked}, 64'd0);
    checkOutput("rstMidValid", {63'd0, wb_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus_ack = 1'b0;
    checkOutput("rstAfterReq", {63'd0, bus_req}, 64'd0);

`ifdef MEM_TIMEOUT_EN
    // Watchdog expires after four un-acked BUS cycles
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 64'h5000, 64'd0, 4'd6, 1'b1, 64'h0055);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
      checkOutput("toBusReq", {63'd0, bus_req}, 64'd1);
    end
    expectBeat(4'd6, 1'b0, 64'd0, 64'h0055, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("toReqDrop", {63'd0, bus_req}, 64'd0);
    checkOutput("toFault", {63'd0, mem_fault}, 64'd1);
    checkOutput("toValid", {63'd0, wb_valid}, 64'd1);
    checkOutput("toWen", {63'd0, wb_wen}, 64'd0);
    @(negedge clk);
    checkOutput("toFaultPulse", {63'd0, mem_fault}, 64'd0);

    // Ack arriving on the same edge as the watchdog wins
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 64'h6000, 64'd0, 4'd2, 1'b1, 64'h0066);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, 2'b00, 64'd0, 64'd0, 4'd0, 1'b0, 64'd0);
    end
    bus_ack   = 1'b1;
    bus_rdata = 64'h600D;
    expectBeat(4'd2, 1'b1, 64'h600D, 64'h0066, 1'b1, 1'b0);
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    checkOutput("ackWinsFault", {63'd0, mem_fault}, 64'd0);
    checkOutput("ackWinsData", wb_data, 64'h600D);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
